// File: rtl/pwm_period_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pwm_period_gen
//  Purpose  : Running period counter plus active duty threshold for the
//             downstream less-than comparator, with an internally generated
//             PWM waveform that matches that comparator bit-for-bit.
//             Period/duty arrive through a valid/ready handshake into a
//             shadow register and are applied only at period boundaries
//             (or right away while idle), so the waveform never glitches.
//  Ports    : clk          - system clock, rising edge
//             reset_n      - asynchronous active-low reset
//             enable       - run when high, pause (hold count) when low
//             clear        - synchronous: count to 0, back to IDLE
//             load_valid   - new period/duty offered
//             load_ready   - shadow register is free
//             period_in    - period in clk cycles
//             duty_in      - high time in clk cycles
//             count        - current count (comparator operand)
//             desired      - active duty (comparator operand)
//             pwm_out      - count < desired while running, else 0
//             period_done  - one-cycle pulse in the cycle count wraps to 0
//             busy         - high while running
//  Options  : ONE_SHOT_EN  - when defined, the first wrap ends in a DONE
//                            state instead of free-running.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_period_gen #(
  parameter int WIDTH = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] desired,
  output logic             pwm_out,
  output logic             period_done,
  output logic             busy
);

`ifdef ONE_SHOT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_desired;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_sh_period;
  logic [WIDTH-1:0] r_sh_duty;
  logic             r_load_ready;
  logic             r_pwm;
  logic             r_period_done;
  logic             r_busy;

  state_t           w_state_nx;
  logic [WIDTH-1:0] w_count_nx;
  logic [WIDTH-1:0] w_desired_nx;
  logic [WIDTH-1:0] w_period_nx;
  logic             w_apply;
  logic             w_pd_nx;
  logic             w_accept;
  logic             w_sh_full;
  logic             w_last;
  logic             w_pwm_nx;
  logic             w_ready_nx;

  always_comb begin
    w_accept     = load_valid && r_load_ready;
    // The shadow is full exactly when the handshake is closed.
    w_sh_full    = !r_load_ready;
    // Equality only: period=1 therefore wraps every cycle.
    w_last       = (r_count == (r_period - WIDTH'(1)));
    w_state_nx   = r_state;
    w_count_nx   = r_count;
    w_desired_nx = r_desired;
    w_period_nx  = r_period;
    w_apply      = 1'b0;
    w_pd_nx      = 1'b0;

    if (clear) begin
      // Highest priority; any pending shadow is kept and applied from IDLE.
      w_state_nx = ST_IDLE;
      w_count_nx = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_count_nx = '0;
          if (w_sh_full) begin
            w_apply      = 1'b1;
            w_period_nx  = r_sh_period;
            w_desired_nx = r_sh_duty;
          end
          // Start needs a non-zero period now and after any shadow update,
          // so RUN never sees a zero period.
          if (enable && (r_period != '0) && (w_period_nx != '0)) begin
            w_state_nx = ST_RUN;
          end
        end

        ST_RUN: begin
          if (enable) begin
            if (w_last) begin
              w_count_nx = '0;
              w_pd_nx    = 1'b1;
              if (w_sh_full) begin
                w_apply      = 1'b1;
                w_period_nx  = r_sh_period;
                w_desired_nx = r_sh_duty;
              end
`ifdef ONE_SHOT_EN
              w_state_nx = ST_DONE;
`else
              if (w_period_nx == '0) begin
                w_state_nx = ST_IDLE;
              end
`endif
            end else begin
              w_count_nx = r_count + WIDTH'(1);
            end
          end
        end

`ifdef ONE_SHOT_EN
        ST_DONE: begin
          // Parked until a new load arrives; it then restarts via IDLE.
          w_count_nx = '0;
          if (w_sh_full) begin
            w_apply      = 1'b1;
            w_period_nx  = r_sh_period;
            w_desired_nx = r_sh_duty;
            w_state_nx   = ST_IDLE;
          end
        end
`endif

        default: begin
          w_state_nx = ST_IDLE;
          w_count_nx = '0;
        end
      endcase
    end

    // Computed from next-cycle values so the registered output lines up
    // with the count/desired ports in the same cycle.
    w_pwm_nx   = (w_state_nx == ST_RUN) && (w_count_nx < w_desired_nx);
    // Accept and apply are mutually exclusive (empty vs. full shadow).
    w_ready_nx = w_accept ? 1'b0 : (w_apply ? 1'b1 : r_load_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_desired     <= '0;
      r_period      <= '0;
      r_sh_period   <= '0;
      r_sh_duty     <= '0;
      r_load_ready  <= 1'b1;
      r_pwm         <= 1'b0;
      r_period_done <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_count       <= w_count_nx;
      r_desired     <= w_desired_nx;
      r_period      <= w_period_nx;
      r_load_ready  <= w_ready_nx;
      r_pwm         <= w_pwm_nx;
      r_period_done <= w_pd_nx;
      r_busy        <= (w_state_nx == ST_RUN);
      if (w_accept) begin
        r_sh_period <= period_in;
        r_sh_duty   <= duty_in;
      end
    end
  end

  assign count       = r_count;
  assign desired     = r_desired;
  assign pwm_out     = r_pwm;
  assign period_done = r_period_done;
  assign busy        = r_busy;
  assign load_ready  = r_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_pwm_period_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_period_gen
//  Purpose  : Self-checking bench for pwm_period_gen. A driver applies
//             directed vectors and queues the hand-computed register state
//             expected after each edge; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_period_gen;

  localparam int WIDTH = 30;
  localparam int X     = -1;  // field not compared

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic             clear;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] period_in;
  logic [WIDTH-1:0] duty_in;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] desired;
  logic             pwm_out;
  logic             period_done;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string nm;
    int    c;
    int    d;
    int    p;
    int    pd;
    int    b;
    int    r;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  pwm_period_gen #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .period_in   (period_in),
    .duty_in     (duty_in),
    .count       (count),
    .desired     (desired),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string f, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        failures++;
        $display("FAIL %s.%s actual=%0d required=%0d (t=%0t)", nm, f, act, exp, $time);
      end
    end
  endtask

  task automatic chk_all(input string nm, input int c, input int d, input int p,
                         input int pd, input int b, input int r);
    cmp(nm, "count",       int'(count),       c);
    cmp(nm, "desired",     int'(desired),     d);
    cmp(nm, "pwm_out",     int'(pwm_out),     p);
    cmp(nm, "period_done", int'(period_done), pd);
    cmp(nm, "busy",        int'(busy),        b);
    cmp(nm, "load_ready",  int'(load_ready),  r);
  endtask

  // Drive one cycle of inputs (called at a negedge) and queue the state
  // expected right after the following rising edge.
  task automatic step(input string nm, input bit en, input bit clr, input bit lv,
                      input int p, input int d,
                      input int ec, input int ed, input int ep,
                      input int epd, input int eb, input int er);
    exp_t e;
    enable     = en;
    clear      = clr;
    load_valid = lv;
    period_in  = WIDTH'(p);
    duty_in    = WIDTH'(d);
    e.nm = nm; e.c = ec; e.d = ed; e.p = ep; e.pd = epd; e.b = eb; e.r = er;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compares one queued expectation per clock, 1 ns after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      m_e = q.pop_front();
      chk_all(m_e.nm, m_e.c, m_e.d, m_e.p, m_e.pd, m_e.b, m_e.r);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    clear      = 1'b0;
    load_valid = 1'b0;
    period_in  = '0;
    duty_in    = '0;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 1);
    reset_n = 1'b1;

    // Load 10/3 in IDLE, then steady waveform.
    step("ld_accept", 1, 0, 1, 10, 3,  0, 0, 0, 0, 0, 0);
    step("ld_apply",  1, 0, 0, 0, 0,   0, 3, 0, 0, 0, 1);
    step("run_start", 1, 0, 0, 0, 0,   0, 3, 1, 0, 1, 1);
    for (int i = 1; i <= 16; i++)
      step("steady", 1, 0, 0, 0, 0, i % 10, 3, int'((i % 10) < 3), int'((i % 10) == 0), 1, 1);

    // Pause at count 6, then resume at 7.
    for (int i = 0; i < 5; i++)
      step("pause", 0, 0, 0, 0, 0, 6, 3, 0, 0, 1, 1);
    for (int i = 7; i <= 15; i++)
      step("resume", 1, 0, 0, 0, 0, i % 10, 3, int'((i % 10) < 3), int'((i % 10) == 0), 1, 1);

    // Mid-run load 4/1 at count 5; old waveform finishes first.
    step("mid_accept", 1, 0, 1, 4, 1, 6, 3, 0, 0, 1, 0);
    step("old_tail",   1, 0, 0, 0, 0, 7, 3, 0, 0, 1, 0);
    step("old_tail",   1, 0, 0, 0, 0, 8, 3, 0, 0, 1, 0);
    step("old_tail",   1, 0, 0, 0, 0, 9, 3, 0, 0, 1, 0);
    step("new_wrap",   1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
    for (int i = 1; i <= 7; i++)
      step("p4d1", 1, 0, 0, 0, 0, i % 4, 1, int'((i % 4) == 0), int'((i % 4) == 0), 1, 1);

    // clear at count 3 (also the wrap point) with a load in the same cycle.
    step("clear_ld",  1, 1, 1, 5, 0, 0, 1, 0, 0, 0, 0);
    step("clr_apply", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("d0_start",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 7; i++)
      step("duty0", 1, 0, 0, 0, 0, i % 5, 0, 0, int'((i % 5) == 0), 1, 1);

    // duty 7 > period 5: constant high.
    step("d7_accept", 1, 0, 1, 5, 7, 3, 0, 0, 0, 1, 0);
    step("d7_tail",   1, 0, 0, 0, 0, 4, 0, 0, 0, 1, 0);
    step("d7_wrap",   1, 0, 0, 0, 0, 0, 7, 1, 1, 1, 1);
    for (int i = 1; i <= 5; i++)
      step("duty7", 1, 0, 0, 0, 0, i % 5, 7, 1, int'((i % 5) == 0), 1, 1);

    // period 1: count pinned at 0, period_done every cycle.
    step("p1_accept", 1, 0, 1, 1, 1, 1, 7, 1, 0, 1, 0);
    for (int i = 2; i <= 4; i++)
      step("p1_tail", 1, 0, 0, 0, 0, i, 7, 1, 0, 1, 0);
    step("p1_wrap", 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++)
      step("p1", 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1);

    // Load accepted on a wrap edge waits for the next wrap.
    step("wrap_accept", 1, 0, 1, 8, 4, 0, 1, 1, 1, 1, 0);
    step("p8_apply",    1, 0, 0, 0, 0, 0, 4, 1, 1, 1, 1);
    for (int i = 1; i <= 4; i++)
      step("p8d4", 1, 0, 0, 0, 0, i, 4, int'(i < 4), 0, 1, 1);

    // Asynchronous reset mid-period.
    #2 reset_n = 1'b0;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    reset_n = 1'b1;
    step("post_reset_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("post_reset_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

`ifdef ONE_SHOT_EN
    step("os_accept", 1, 0, 1, 6, 2, 0, 0, 0, 0, 0, 0);
    step("os_apply",  1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1);
    step("os_start",  1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 1);
    for (int i = 1; i <= 5; i++)
      step("os_run", 1, 0, 0, 0, 0, i, 2, int'(i < 2), 0, 1, 1);
    step("os_wrap", 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      step("os_done_hold", 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1);
    step("os_clear", 1, 1, 0, 0, 0, 0, 2, 0, 0, 0, 1);
    step("os_rerun", 1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 1);
`endif

    // Every queued expectation must have been consumed by the monitor.
    cmp("drain", "queue_left", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_period_gen.md
Name: pwm_period_gen

Overview:
- Produces the 30-bit running `count` and the active `desired` (duty) threshold consumed by the team's less-than comparator.
- Also generates the PWM waveform internally, so the output matches what a comparator driven by these ports would produce.
- Period and duty are loaded through a valid/ready handshake into shadow registers. They are applied glitch-free at period boundaries.
- Sits between the control/FSM logic and the output-stage/comparator path (motor, LED and buzzer drive).

Parameters:
- WIDTH, 30, bit width of count, period and duty. All arithmetic is unsigned in WIDTH bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  run when high; pause (hold count) when low
- clear  input  1  synchronous: count<=0, return to IDLE
- load_valid  input  1  new period/duty offered
- load_ready  output  1  shadow register free
- period_in  input  WIDTH  period in clk cycles
- duty_in  input  WIDTH  high-time in clk cycles
- count  output  WIDTH  current count (comparator `count` operand)
- desired  output  WIDTH  active duty (comparator `desired` operand)
- pwm_out  output  1  count < desired while RUN, else 0
- period_done  output  1  one-cycle pulse on wrap
- busy  output  1  high in RUN

Behaviour:
- Reset (async, reset_n=0) clears all state:
  - count=0, desired=0, active period=0
  - shadow empty, load_ready=1
  - pwm_out=0, period_done=0, busy=0, state=IDLE
- States:
  - IDLE: count held at 0, pwm_out=0. Moves to RUN on the next edge when enable=1 and active period!=0.
  - RUN with enable=1: count increments by 1 per cycle.
  - RUN with enable=0: count, pwm_out and state frozen (pause, not stop).
- Wrap:
  - When count==period-1 and enable=1, count goes to 0 and period_done pulses high for the cycle in which count==0.
  - Compare is ==, never >=. Therefore period=1 keeps count at 0 and pulses period_done every cycle.
- pwm_out:
  - Registered, but equal to (count < desired) for the count/desired values present in the same cycle. It has no lag relative to the count port.
  - desired=0 gives constant 0.
  - desired>=period gives constant 1 in RUN.
- Load handshake:
  - A transfer occurs when load_valid && load_ready at the edge. period_in/duty_in go to the shadow, and load_ready drops the next cycle.
  - In IDLE, the shadow is applied on the following edge and load_ready returns to 1.
  - In RUN, the shadow is applied on the wrap edge, when count becomes 0, and load_ready returns to 1 on that same edge.
  - A transfer accepted on a wrap edge is NOT applied at that wrap. It is applied at the next wrap.
  - A loaded period=0 while in RUN forces IDLE at the wrap where it is applied.
- clear:
  - Takes priority over enable and wrap: count=0, state IDLE, pwm_out=0, no period_done.
  - clear does not discard a pending shadow, and clear does not block a handshake in the same cycle.
- Reset mid-operation abandons everything, including the shadow. No period_done is generated.

Optional Feature:
- ONE_SHOT_EN
- Defined:
  - Adds state DONE. On the first wrap in RUN, go to DONE: count=0, pwm_out=0, busy=0, period_done pulses once.
  - DONE is left only via clear, which returns to IDLE, or via a new load handshake, which applies the shadow and then runs if enable=1.
- Undefined: free-running periodic operation as described above; DONE does not exist.

Test Plan:
- Load, run, steady waveform:
  - Stimulus: reset, load period=10, duty=3 in IDLE, enable=1.
  - Required: count goes 0..9 and repeats; pwm_out high on count 0,1,2; period_done pulses on every count==0 after a wrap.
- Mid-run load:
  - Stimulus: mid-run load period=4, duty=1 while count=5.
  - Required: old 10/3 waveform completes to 9; new 4/1 waveform starts at the wrap; load_ready is low from the cycle after acceptance until that wrap.
- Pause with enable=0:
  - Stimulus: enable=0 at count=6 for 5 cycles.
  - Required: count stays at 6 and pwm_out stays constant; after re-enable, count resumes at 7 with no extra period_done.
- Boundary duty/period:
  - Stimulus: duty=0 and period=5; then duty=7 and period=5; then period=1.
  - Required: pwm_out constant 0; then constant 1; then count=0 with period_done high every cycle.
- clear and asynchronous reset:
  - Stimulus: clear at count=3 with load_valid=1 in the same cycle.
  - Required: count goes to 0 and state to IDLE; the load is accepted and applied the next cycle.
  - Stimulus: reset_n low mid-period, asynchronously.
  - Required: all outputs go to reset values immediately.
- ONE_SHOT_EN:
  - Stimulus: period=6 with ONE_SHOT_EN defined.
  - Required: exactly one period_done, then busy=0 and count held at 0 until clear or a new load.
